// File: rtl/bus_read_control_pkg.sv
// rtl/bus_read_control_pkg.sv - shared constants, read source type and poll word builder
package bus_read_control_pkg;

    localparam int BUS_W          = 8;
    localparam int LEVEL_W        = 3;
    localparam int POLL_VALID_BIT = 7;
    localparam int POLL_LEVEL_MSB = 2;
    localparam int POLL_LEVEL_LSB = 0;
    localparam int OCW3_POLL_BIT  = 2;

    typedef enum logic [1:0] {
        SRC_POLL,
        SRC_IMR,
        SRC_ISR,
        SRC_IRR
    } read_src_e;

    function automatic logic [BUS_W-1:0] poll_word(input logic valid, input logic [LEVEL_W-1:0] level);
        logic [BUS_W-1:0] word;
        word                                = '0;
        word[POLL_VALID_BIT]                = valid;
        word[POLL_LEVEL_MSB:POLL_LEVEL_LSB] = level;
        return word;
    endfunction

endpackage

// File: rtl/bus_read_control_if.sv
// rtl/bus_read_control_if.sv - CPU read cycle, OCW3/ICW1 strobes and register/data bus signals
interface bus_read_control_if;
    import bus_read_control_pkg::*;

    logic               chip_select_n;
    logic               read_enable_n;
    logic               address;
    logic               write_initial_command_word_1;
    logic               write_operation_control_word_3_registers;
    logic [BUS_W-1:0]   internal_data_bus;
    logic               read_register_isr_or_irr;
    logic [BUS_W-1:0]   interrupt_mask;
    logic [BUS_W-1:0]   interrupt_request_register;
    logic [BUS_W-1:0]   in_service_register;
    logic [BUS_W-1:0]   highest_level_in_request;
    logic [BUS_W-1:0]   data_bus_out;
    logic               data_bus_drive_enable;
    logic               freeze;
    logic [BUS_W-1:0]   poll_set_in_service;

    modport master (
        output chip_select_n, read_enable_n, address,
        output write_initial_command_word_1, write_operation_control_word_3_registers,
        output internal_data_bus, read_register_isr_or_irr,
        output interrupt_mask, interrupt_request_register, in_service_register,
        output highest_level_in_request,
        input  data_bus_out, data_bus_drive_enable, freeze, poll_set_in_service
    );

    modport slave (
        input  chip_select_n, read_enable_n, address,
        input  write_initial_command_word_1, write_operation_control_word_3_registers,
        input  internal_data_bus, read_register_isr_or_irr,
        input  interrupt_mask, interrupt_request_register, in_service_register,
        input  highest_level_in_request,
        output data_bus_out, data_bus_drive_enable, freeze, poll_set_in_service
    );

endinterface

// File: rtl/bus_read_control_one_hot_to_index.sv
// rtl/bus_read_control_one_hot_to_index.sv - one-hot to binary index, lowest set bit wins, 0 for none
module one_hot_to_index
    import bus_read_control_pkg::*;
(
    input  logic [BUS_W-1:0]   one_hot,
    output logic [LEVEL_W-1:0] index
);

    always_comb begin
        index = '0;
        for (int i = BUS_W - 1; i >= 0; i--) begin
            if (one_hot[i]) begin
                index = LEVEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_read_control.sv
// rtl/bus_read_control.sv - read-side data selection, poll handling and freeze for the interrupt controller
module bus_read_control
    import bus_read_control_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    bus_read_control_if.slave  bus
);

    logic               read_active;
    logic               read_start;
    logic               read_end;
    logic               ocw3_poll;
    logic               unused_bus_bits;
    logic [LEVEL_W-1:0] poll_level;
    read_src_e          src;

    logic               read_active_q, read_active_d;
    logic               poll_armed_q, poll_armed_d;
    logic [BUS_W-1:0]   data_q, data_d;
    logic               drive_q, drive_d;
    logic               freeze_q, freeze_d;
    logic [BUS_W-1:0]   set_isr_q, set_isr_d;

    assign read_active     = !bus.chip_select_n && !bus.read_enable_n;
    assign read_start      = read_active && !read_active_q;
    assign read_end        = !read_active && read_active_q;
    assign ocw3_poll       = bus.write_operation_control_word_3_registers
                             && bus.internal_data_bus[OCW3_POLL_BIT];
    assign unused_bus_bits = ^bus.internal_data_bus;

    one_hot_to_index u_level_index (
        .one_hot (bus.highest_level_in_request),
        .index   (poll_level)
    );

    always_comb begin
        if (poll_armed_q) begin
            src = SRC_POLL;
        end else if (bus.address) begin
            src = SRC_IMR;
        end else if (bus.read_register_isr_or_irr) begin
            src = SRC_ISR;
        end else begin
            src = SRC_IRR;
        end
    end

    always_comb begin
        read_active_d = read_active;
        drive_d       = read_active;
        data_d        = data_q;
        freeze_d      = freeze_q;
        set_isr_d     = '0;
        poll_armed_d  = poll_armed_q;

        if (read_start) begin
            case (src)
                SRC_POLL: data_d = poll_word(|bus.highest_level_in_request, poll_level);
                SRC_IMR:  data_d = bus.interrupt_mask;
                SRC_ISR:  data_d = bus.in_service_register;
                default:  data_d = bus.interrupt_request_register;
            endcase
            freeze_d = poll_armed_q;
            if (poll_armed_q) begin
                set_isr_d = bus.highest_level_in_request;
            end
        end else if (read_end) begin
            data_d   = '0;
            freeze_d = 1'b0;
        end

        // The poll read consumes the armed flag at its start, so an OCW3 poll
        // written while that read is still in progress arms the following read.
        if (bus.write_initial_command_word_1) begin
            poll_armed_d = 1'b0;
        end else if (read_start && poll_armed_q) begin
            poll_armed_d = 1'b0;
        end else if (ocw3_poll) begin
            poll_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_active_q <= 1'b0;
            poll_armed_q  <= 1'b0;
            data_q        <= '0;
            drive_q       <= 1'b0;
            freeze_q      <= 1'b0;
            set_isr_q     <= '0;
        end else begin
            read_active_q <= read_active_d;
            poll_armed_q  <= poll_armed_d;
            data_q        <= data_d;
            drive_q       <= drive_d;
            freeze_q      <= freeze_d;
            set_isr_q     <= set_isr_d;
        end
    end

    assign bus.data_bus_out          = data_q;
    assign bus.data_bus_drive_enable = drive_q;
    assign bus.freeze                = freeze_q;
    assign bus.poll_set_in_service   = set_isr_q;

endmodule

// File: tb/tb_bus_read_control.sv
// tb/tb_bus_read_control.sv - directed and randomized checks of bus_read_control against a behavioural model
module tb_bus_read_control;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    bus_read_control_if bus_if ();

    bus_read_control dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clock = ~clock;

    int errors   = 0;
    int checks   = 0;
    bit check_en = 1'b0;

    bit         m_ra, m_armed, m_poll;
    logic [7:0] m_latched;
    logic [7:0] nxt_data, exp_data, nxt_psis, exp_psis;
    logic       nxt_drive, exp_drive, nxt_freeze, exp_freeze;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_ra = 0; m_armed = 0; m_poll = 0; m_latched = '0;
        nxt_data = '0; nxt_psis = '0; nxt_drive = 0; nxt_freeze = 0;
        exp_data = '0; exp_psis = '0; exp_drive = 0; exp_freeze = 0;
    endtask

    // What the outputs must show after the coming rising edge, from the inputs now applied.
    task automatic model_edge();
        bit ra, start, poll_wr;
        logic [7:0] h;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ra      = !bus_if.chip_select_n && !bus_if.read_enable_n;
        start   = ra && !m_ra;
        poll_wr = bus_if.write_operation_control_word_3_registers && bus_if.internal_data_bus[2];
        h       = bus_if.highest_level_in_request;
        nxt_psis = '0;
        if (start) begin
            m_poll = m_armed;
            if (m_armed) begin
                m_latched = ((h != 0) ? 8'h80 : 8'h00) + 8'($clog2(h));
                nxt_psis  = h;
            end else if (bus_if.address) begin
                m_latched = bus_if.interrupt_mask;
            end else if (bus_if.read_register_isr_or_irr) begin
                m_latched = bus_if.in_service_register;
            end else begin
                m_latched = bus_if.interrupt_request_register;
            end
        end
        if (bus_if.write_initial_command_word_1)  m_armed = 0;
        else if (start && m_armed)                m_armed = 0;
        else if (poll_wr)                         m_armed = 1;
        nxt_drive  = ra;
        nxt_data   = ra ? m_latched : 8'h00;
        nxt_freeze = ra && m_poll;
        m_ra       = ra;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clock);
        #1;
        exp_data = nxt_data; exp_psis = nxt_psis; exp_drive = nxt_drive; exp_freeze = nxt_freeze;
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check8("data_bus_out", bus_if.data_bus_out, exp_data);
            check1("drive_enable", bus_if.data_bus_drive_enable, exp_drive);
            check1("freeze", bus_if.freeze, exp_freeze);
            check8("poll_set_in_service", bus_if.poll_set_in_service, exp_psis);
        end
    end

    task automatic rd_on();  bus_if.chip_select_n = 0; bus_if.read_enable_n = 0; cyc(); endtask
    task automatic rd_off(); bus_if.chip_select_n = 1; bus_if.read_enable_n = 1; cyc(); endtask

    task automatic ocw3_write(input logic [7:0] d);
        bus_if.write_operation_control_word_3_registers = 1;
        bus_if.internal_data_bus = d;
        cyc();
        bus_if.write_operation_control_word_3_registers = 0;
        bus_if.internal_data_bus = 8'h00;
    endtask

    task automatic icw1_write();
        bus_if.write_initial_command_word_1 = 1;
        cyc();
        bus_if.write_initial_command_word_1 = 0;
    endtask

    initial begin
        bus_if.chip_select_n = 1; bus_if.read_enable_n = 1; bus_if.address = 0;
        bus_if.write_initial_command_word_1 = 0;
        bus_if.write_operation_control_word_3_registers = 0;
        bus_if.internal_data_bus = 0; bus_if.read_register_isr_or_irr = 0;
        bus_if.interrupt_mask = 0; bus_if.interrupt_request_register = 0;
        bus_if.in_service_register = 0; bus_if.highest_level_in_request = 0;
        model_reset();
        #1 reset_n = 0;
        #1 check_en = 1;
        cyc(); cyc();
        check8("reset_data", bus_if.data_bus_out, 8'h00);
        check1("reset_drive", bus_if.data_bus_drive_enable, 1'b0);
        check1("reset_freeze", bus_if.freeze, 1'b0);
        check8("reset_psis", bus_if.poll_set_in_service, 8'h00);
        reset_n = 1;
        cyc();

        bus_if.interrupt_mask = 8'hA5; bus_if.address = 1;
        rd_on();
        check8("imr_read", bus_if.data_bus_out, 8'hA5);
        check1("imr_drive_on", bus_if.data_bus_drive_enable, 1'b1);
        cyc();
        rd_off();
        check1("imr_drive_off", bus_if.data_bus_drive_enable, 1'b0);

        bus_if.address = 0; bus_if.interrupt_request_register = 8'h12;
        rd_on(); check8("irr_read", bus_if.data_bus_out, 8'h12); rd_off();
        bus_if.read_register_isr_or_irr = 1; bus_if.in_service_register = 8'h40;
        rd_on(); check8("isr_read", bus_if.data_bus_out, 8'h40); rd_off();

        bus_if.read_register_isr_or_irr = 0; bus_if.interrupt_request_register = 8'h33;
        ocw3_write(8'h0C);
        bus_if.highest_level_in_request = 8'h20;
        rd_on();
        check8("poll_word", bus_if.data_bus_out, 8'h85);
        check8("poll_set_isr", bus_if.poll_set_in_service, 8'h20);
        check1("poll_freeze", bus_if.freeze, 1'b1);
        cyc();
        check8("poll_set_isr_pulse_end", bus_if.poll_set_in_service, 8'h00);
        check1("poll_freeze_held", bus_if.freeze, 1'b1);
        rd_off();
        check1("poll_freeze_release", bus_if.freeze, 1'b0);
        rd_on(); check8("after_poll_irr", bus_if.data_bus_out, 8'h33); rd_off();

        ocw3_write(8'h04);
        bus_if.highest_level_in_request = 8'h00;
        rd_on();
        check8("poll_none_word", bus_if.data_bus_out, 8'h00);
        check8("poll_none_psis", bus_if.poll_set_in_service, 8'h00);
        rd_off();

        ocw3_write(8'h0C); icw1_write();
        bus_if.highest_level_in_request = 8'h20;
        rd_on();
        check8("icw1_cancel_data", bus_if.data_bus_out, 8'h33);
        check1("icw1_cancel_freeze", bus_if.freeze, 1'b0);
        rd_off();
        ocw3_write(8'h0C);
        rd_on();
        icw1_write();
        check8("icw1_mid_data", bus_if.data_bus_out, 8'h85);
        check1("icw1_mid_freeze", bus_if.freeze, 1'b1);
        rd_off();
        check1("icw1_mid_release", bus_if.freeze, 1'b0);
        rd_on(); check1("icw1_next_not_poll", bus_if.freeze, 1'b0); rd_off();

        ocw3_write(8'h0C);
        rd_on();
        #2 reset_n = 0;
        model_reset();
        #1;
        check8("async_rst_data", bus_if.data_bus_out, 8'h00);
        check1("async_rst_drive", bus_if.data_bus_drive_enable, 1'b0);
        check1("async_rst_freeze", bus_if.freeze, 1'b0);
        cyc(); cyc();
        reset_n = 1;
        cyc();
        check8("post_rst_restart", bus_if.data_bus_out, 8'h33);
        check1("post_rst_not_poll", bus_if.freeze, 1'b0);
        rd_off();

        for (int i = 0; i < 2000; i++) begin
            if (!bus_if.read_enable_n) bus_if.read_enable_n = ($urandom_range(0, 3) == 0);
            else                       bus_if.read_enable_n = ($urandom_range(0, 3) != 0);
            bus_if.chip_select_n = ($urandom_range(0, 9) == 0);
            bus_if.address = 1'($urandom_range(0, 1));
            bus_if.read_register_isr_or_irr = 1'($urandom_range(0, 1));
            bus_if.interrupt_mask = 8'($urandom);
            bus_if.interrupt_request_register = 8'($urandom);
            bus_if.in_service_register = 8'($urandom);
            bus_if.highest_level_in_request = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h01 << $urandom_range(0, 7));
            bus_if.write_initial_command_word_1 = ($urandom_range(0, 19) == 0);
            bus_if.write_operation_control_word_3_registers = ($urandom_range(0, 4) == 0);
            bus_if.internal_data_bus = 8'($urandom);
            cyc();
        end
        bus_if.write_initial_command_word_1 = 0;
        bus_if.write_operation_control_word_3_registers = 0;
        rd_off(); cyc();
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
